multicycle_control: RTL and testbench
=====================================

# multicycle_control

Moore-style control FSM that sequences a shared-memory, multi-cycle MIPS datapath. It is the multi-cycle counterpart of the single-cycle opcode decoder. It drives a single ALU and a single unified memory across FETCH/DECODE/EXECUTE/MEM/WB steps, with a ready handshake on every memory access. It sits between the instruction register's opcode field and the datapath muxes and enables.

## Interface
Parameters:
- None. Widths are fixed by the ISA.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  reset: one clock; reset is synchronous and active-high.
- OP_Code  in  6  IR[31:26], valid from DECODE onward.
- Zero  in  1  ALU zero flag.
- MemReady  in  1  memory completes the current access this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load if Zero.
- IorD  out  1  memory address: 0=PC, 1=ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register load.
- MemtoReg  out  1  register write data: 0=ALUOut, 1=MDR.
- RegDst  out  1  write address: 0=rt, 1=rd.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  0=PC, 1=rs.
- ALUSrcB  out  2  00=rt, 01=const 4, 10=signext, 11=signext<<2.
- ALUOp  out  2  00=add, 01=sub, 10=funct-decoded.
- PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target.
- State  out  4  current state, for debug.
- Illegal  out  1  unsupported opcode seen in DECODE.

## Operation
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11. Codes 12–15 are unreachable; if entered, next state is FETCH and all outputs are 0.
- Every output not listed for a state is 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=PCWrite=MemReady. Stay in FETCH until MemReady=1, then go to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute). Next state by opcode:
  - 100011 or 101011 → MEM_ADDR
  - 000000 → R_EXEC
  - 000100 → BRANCH
  - 000010 → JUMP
  - 001000 → ADDI_EXEC
  - any other opcode → FETCH with Illegal=1 this cycle.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next is MEM_READ if OP=100011, else MEM_WRITE.
- MEM_READ: MemRead=1, IorD=1. Hold until MemReady, then go to MEM_WB.
- MEM_WB: RegDst=0, MemtoReg=1, RegWrite=1, then FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Hold until MemReady, then go to FETCH.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10, then R_WB. R_WB: RegDst=1, MemtoReg=0, RegWrite=1, then FETCH.
- ADDI_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00, then ADDI_WB. ADDI_WB: RegDst=0, MemtoReg=0, RegWrite=1, then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, then FETCH.
- JUMP: PCWrite=1, PCSource=10, then FETCH.
- Effective PC load = PCWrite | (PCWriteCond & Zero). The datapath forms this term; the FSM only drives the two enables.

## Timing
- State register updates on the rising CLK edge. Outputs decode combinationally from State, plus MemReady in FETCH.
- While RST=1, every output is forced to 0, including State=0 and Illegal=0. The edge on which RST=1 is sampled loads FETCH.
- Reset in the middle of an instruction abandons it. No write enable may assert in the cycle RST is high.
- With MemReady held at 1, cycles per instruction are: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each cycle MemReady=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle. Request signals stay asserted and stable for the whole wait.
- IRWrite and PCWrite assert for exactly one cycle per fetch: the cycle FETCH sees MemReady=1.
- MemReady is ignored in every state other than FETCH, MEM_READ and MEM_WRITE.

## Structure
- Shared package `mc_ctrl_pkg` holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI;
  - the 4-bit state encodings;
  - ALUOp codes;
  - ALUSrcB and PCSource select codes.
- One sub-module is natural: `mc_ctrl_outdec`, a pure combinational state-to-control-word decoder. The next-state logic and the state register stay in the top module.

## Test plan
- Reset: RST=1 for 2 cycles in any state → all outputs 0 during reset; State=0 on the first cycle after release; FETCH outputs visible with MemRead=1.
- lw with MemReady=1: State goes 0→1→2→3→4→0. RegWrite=1 and MemtoReg=1 only in state 4. Total 5 cycles.
- sw with MemReady low 3 cycles in MEM_WRITE: MemWrite=1 and IorD=1 stay stable for 4 cycles, then State=0. RegWrite is never 1.
- beq: State 0→1→8→0. In state 8: PCWriteCond=1, PCSource=01, ALUOp=01, PCWrite=0.
- Opcode 111111: DECODE asserts Illegal=1 for one cycle, next State=0, no write enable asserted.
- Fetch stall: MemReady=0 for 2 cycles in FETCH → IRWrite=0 and PCWrite=0 during the stall. Both are 1 only on the ready cycle, then State=1.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | mc_ctrl_pkg : opcodes, state codes and control select codes for the  |
// |               multi-cycle MIPS control FSM.          Rev 1.0         |
// +----------------------------------------------------------------------+
`default_nettype none

package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } ctrl_t;

  function automatic logic op_is_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_ctrl_outdec.sv
// +----------------------------------------------------------------------+
// | mc_ctrl_outdec : combinational state-to-control-word decoder.        |
// |                                                      Rev 1.0         |
// +----------------------------------------------------------------------+
`default_nettype none

module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  logic [3:0] i_state,
  input  logic       i_mem_ready,
  input  logic [5:0] i_op,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.alu_op    = ALUOP_ADD;
        o_ctrl.pc_source = PCSRC_ALU;
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_write  = i_mem_ready;
      end
      S_DECODE: begin
        o_ctrl.alu_src_b = SRCB_IMM_SH2;
        o_ctrl.alu_op    = ALUOP_ADD;
        o_ctrl.illegal   = !op_is_legal(i_op);
      end
      S_MEM_ADDR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.reg_write  = 1'b1;
      end
      S_MEM_WRITE: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_RT;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        o_ctrl.reg_dst   = 1'b1;
        o_ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = SRCB_RT;
        o_ctrl.alu_op        = ALUOP_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = PCSRC_JUMP;
      end
      S_ADDI_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_ADDI_WB: begin
        o_ctrl.reg_write = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// +----------------------------------------------------------------------+
// | multicycle_control : Moore control FSM for a shared-memory,          |
// |                      multi-cycle MIPS datapath.      Rev 1.0         |
// +----------------------------------------------------------------------+
`default_nettype none

module multicycle_control
  import mc_ctrl_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] OP_Code,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] State,
  output logic       Illegal
);

  state_t r_state;
  state_t w_next;
  ctrl_t  w_ctrl;
  logic   w_unused_zero;

  // Branch resolution (PCWriteCond & Zero) is formed in the datapath.
  assign w_unused_zero = Zero;

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:     w_next = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (OP_Code)
          OP_LW, OP_SW: w_next = S_MEM_ADDR;
          OP_RTYPE:     w_next = S_R_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          OP_ADDI:      w_next = S_ADDI_EXEC;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  w_next = (OP_Code == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  w_next = MemReady ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    w_next = S_FETCH;
      S_MEM_WRITE: w_next = MemReady ? S_FETCH : S_MEM_WRITE;
      S_R_EXEC:    w_next = S_R_WB;
      S_R_WB:      w_next = S_FETCH;
      S_BRANCH:    w_next = S_FETCH;
      S_JUMP:      w_next = S_FETCH;
      S_ADDI_EXEC: w_next = S_ADDI_WB;
      S_ADDI_WB:   w_next = S_FETCH;
      default:     w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  mc_ctrl_outdec u_outdec (
    .i_state     (r_state),
    .i_mem_ready (MemReady),
    .i_op        (OP_Code),
    .o_ctrl      (w_ctrl)
  );

  // Every output, State included, reads as zero while reset is held.
  assign PCWrite     = w_ctrl.pc_write      & ~RST;
  assign PCWriteCond = w_ctrl.pc_write_cond & ~RST;
  assign IorD        = w_ctrl.i_or_d        & ~RST;
  assign MemRead     = w_ctrl.mem_read      & ~RST;
  assign MemWrite    = w_ctrl.mem_write     & ~RST;
  assign IRWrite     = w_ctrl.ir_write      & ~RST;
  assign MemtoReg    = w_ctrl.mem_to_reg    & ~RST;
  assign RegDst      = w_ctrl.reg_dst       & ~RST;
  assign RegWrite    = w_ctrl.reg_write     & ~RST;
  assign ALUSrcA     = w_ctrl.alu_src_a     & ~RST;
  assign ALUSrcB     = w_ctrl.alu_src_b     & {2{~RST}};
  assign ALUOp       = w_ctrl.alu_op        & {2{~RST}};
  assign PCSource    = w_ctrl.pc_source     & {2{~RST}};
  assign Illegal     = w_ctrl.illegal       & ~RST;
  assign State       = r_state              & {4{~RST}};

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// +----------------------------------------------------------------------+
// | tb_multicycle_control : directed scoreboard bench for the control    |
// |                         FSM.                         Rev 1.0         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_multicycle_control;

  localparam logic [3:0] FE = 4'd0,  DE = 4'd1,  MA = 4'd2,  MR = 4'd3;
  localparam logic [3:0] MB = 4'd4,  MW = 4'd5,  RE = 4'd6,  RB = 4'd7;
  localparam logic [3:0] BR = 4'd8,  JP = 4'd9,  AE = 4'd10, AB = 4'd11;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BQ = 6'b000100, JJ = 6'b000010, AD = 6'b001000;
  localparam logic [5:0] BAD = 6'b111111;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [5:0] OP_Code = 6'd0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, Illegal;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] State;

  int total = 0;
  int bad   = 0;
  int step_no = 0;
  logic [20:0] exp_q[$];

  always #5 CLK = ~CLK;

  multicycle_control dut (
    .CLK(CLK), .RST(RST), .OP_Code(OP_Code), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .State(State), .Illegal(Illegal)
  );

  // Control word per state, written out from the state table.
  function automatic logic [20:0] exp_word(input logic [3:0] st, input logic rdy,
                                           input logic ill);
    logic pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, srca;
    logic [1:0] srcb, aluop, pcsrc;
    {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, srca} = '0;
    srcb = 2'b00; aluop = 2'b00; pcsrc = 2'b00;
    case (st)
      4'd0:  begin mr = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
      4'd1:  srcb = 2'b11;
      4'd2:  begin srca = 1; srcb = 2'b10; end
      4'd3:  begin mr = 1; iord = 1; end
      4'd4:  begin m2r = 1; rw = 1; end
      4'd5:  begin mw = 1; iord = 1; end
      4'd6:  begin srca = 1; aluop = 2'b10; end
      4'd7:  begin rdst = 1; rw = 1; end
      4'd8:  begin srca = 1; aluop = 2'b01; pcwc = 1; pcsrc = 2'b01; end
      4'd9:  begin pcw = 1; pcsrc = 2'b10; end
      4'd10: begin srca = 1; srcb = 2'b10; end
      4'd11: rw = 1;
      default: ;
    endcase
    return {st, pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, srca,
            srcb, aluop, pcsrc, ill};
  endfunction

  task automatic step(input logic rst, input logic [5:0] op, input logic rdy,
                      input logic z, input logic [3:0] st, input logic ill);
    @(posedge CLK);
    #1;
    RST = rst; OP_Code = op; MemReady = rdy; Zero = z;
    exp_q.push_back(rst ? 21'd0 : exp_word(st, rdy, ill));
  endtask

  // Monitor: the FSM presents a control word every cycle.
  always @(negedge CLK) begin
    logic [20:0] act, e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      act = {State, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
             MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, Illegal};
      total++;
      step_no++;
      if (act !== e) begin
        bad++;
        $display("FAIL ctrl_word step %0d: got %h expected %h", step_no, act, e);
      end
    end
  end

  initial begin
    // reset held two cycles
    step(1, LW, 0, 0, FE, 0); step(1, LW, 1, 0, FE, 0);
    // fetch stall, then lw; MemReady low in DECODE is ignored
    step(0, LW, 0, 0, FE, 0); step(0, LW, 0, 0, FE, 0); step(0, LW, 1, 0, FE, 0);
    step(0, LW, 0, 0, DE, 0); step(0, LW, 0, 0, MA, 0);
    step(0, LW, 1, 0, MR, 0); step(0, LW, 0, 0, MB, 0);
    // sw with three wait cycles in MEM_WRITE
    step(0, SW, 1, 0, FE, 0); step(0, SW, 1, 0, DE, 0); step(0, SW, 1, 0, MA, 0);
    step(0, SW, 0, 0, MW, 0); step(0, SW, 0, 0, MW, 0); step(0, SW, 0, 0, MW, 0);
    step(0, SW, 1, 0, MW, 0);
    // R-type
    step(0, RT, 1, 0, FE, 0); step(0, RT, 1, 0, DE, 0);
    step(0, RT, 1, 0, RE, 0); step(0, RT, 1, 0, RB, 0);
    // addi
    step(0, AD, 1, 0, FE, 0); step(0, AD, 1, 0, DE, 0);
    step(0, AD, 1, 0, AE, 0); step(0, AD, 1, 0, AB, 0);
    // beq
    step(0, BQ, 1, 0, FE, 0); step(0, BQ, 1, 1, DE, 0); step(0, BQ, 1, 1, BR, 0);
    // j
    step(0, JJ, 1, 0, FE, 0); step(0, JJ, 1, 0, DE, 0); step(0, JJ, 1, 0, JP, 0);
    // unsupported opcode
    step(0, BAD, 1, 0, FE, 0); step(0, BAD, 1, 0, DE, 1);
    // lw with one wait cycle in MEM_READ
    step(0, LW, 1, 0, FE, 0); step(0, LW, 1, 0, DE, 0); step(0, LW, 1, 0, MA, 0);
    step(0, LW, 0, 0, MR, 0); step(0, LW, 1, 0, MR, 0); step(0, LW, 1, 0, MB, 0);
    // reset in the middle of an R-type
    step(0, RT, 1, 0, FE, 0); step(0, RT, 1, 0, DE, 0); step(0, RT, 1, 0, RE, 0);
    step(1, RT, 1, 0, FE, 0); step(1, RT, 1, 0, FE, 0);
    step(0, RT, 0, 0, FE, 0); step(0, RT, 1, 0, FE, 0); step(0, RT, 1, 0, DE, 0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge CLK);
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
